// File: rtl/pipelined_dot_mac.sv
// Three-stage pipelined dot-product / multiply-accumulate unit with valid/ready
// handshaking. The whole pipeline freezes while the output is held by the consumer.
module pipelined_dot_mac #(
    parameter int WIDTH = 32,
    parameter int LANES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] a_flat,
    input  logic [LANES*WIDTH-1:0] b_flat,
    input  logic                   acc_mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       c
);

    logic                   s1_valid_q, s1_valid_d;
    logic [LANES*WIDTH-1:0] s1_a_q, s1_a_d;
    logic [LANES*WIDTH-1:0] s1_b_q, s1_b_d;
    logic                   s1_mode_q, s1_mode_d;

    logic                   s2_valid_q, s2_valid_d;
    logic [LANES*WIDTH-1:0] s2_prod_q, s2_prod_d;
    logic                   s2_mode_q, s2_mode_d;

    logic                   s3_valid_q, s3_valid_d;
    logic [WIDTH-1:0]       c_q, c_d;
    logic [WIDTH-1:0]       acc_q, acc_d;

    logic                   stall;
    logic [WIDTH-1:0]       lane_sum;

    assign stall     = s3_valid_q & ~out_ready;
    // Reset overrides backpressure so the reset edge always looks ready.
    assign in_ready  = reset | ~stall;
    assign out_valid = s3_valid_q;
    assign c         = c_q;

    always_comb begin
        lane_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + s2_prod_q[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        s2_prod_d  = s2_prod_q;
        s2_mode_d  = s2_mode_q;
        s3_valid_d = s3_valid_q;
        c_d        = c_q;
        acc_d      = acc_q;

        if (!stall) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d    = a_flat;
                s1_b_d    = b_flat;
                s1_mode_d = acc_mode;
            end

            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_mode_d = s1_mode_q;
                for (int unsigned i = 0; i < LANES; i++) begin
                    s2_prod_d[i*WIDTH +: WIDTH] = s1_a_q[i*WIDTH +: WIDTH] * s1_b_q[i*WIDTH +: WIDTH];
                end
            end

            // Bubbles advance into S3 but leave c and the accumulator untouched.
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                c_d   = s2_mode_q ? (acc_q + lane_sum) : lane_sum;
                acc_d = c_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_mode_q  <= 1'b0;
            s3_valid_q <= 1'b0;
            c_q        <= '0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_prod_q  <= s2_prod_d;
            s2_mode_q  <= s2_mode_d;
            s3_valid_q <= s3_valid_d;
            c_q        <= c_d;
            acc_q      <= acc_d;
        end
    end

endmodule

// File: doc/pipelined_dot_mac.md
PIPELINED_DOT_MAC -- requirements
Module: pipelined_dot_mac

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits (legal 8..32).
REQ-002 Parameter LANES, default 2, number of multiply channels per dot product (legal 1..8).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 a_flat  input  LANES*WIDTH  operand A vector; lane i is bits [i*WIDTH +: WIDTH].
REQ-006 b_flat  input  LANES*WIDTH  operand B vector; same lane packing as a_flat.
REQ-007 acc_mode  input  1  0 = result is the plain dot product; 1 = dot product is added to the accumulator.
REQ-008 in_valid  input  1  a_flat, b_flat and acc_mode are valid this cycle.
REQ-009 in_ready  output  1  block accepts an input this cycle.
REQ-010 out_valid  output  1  c holds a valid result.
REQ-011 out_ready  input  1  consumer takes c this cycle.
REQ-012 c  output  WIDTH  result.

Function
REQ-013 An input SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; no other edge accepts.
REQ-014 Pipeline SHALL have three register stages: S1 captures operands and acc_mode; S2 holds the LANES products a_i*b_i; S3 holds c and the accumulator.
REQ-015 Each stage SHALL carry a valid bit; out_valid SHALL equal the S3 valid bit.
REQ-016 No stall: an input accepted on edge N SHALL appear on c with out_valid=1 after edge N+2 (latency 3 edges counting N); throughput one result per cycle.
REQ-017 Stall condition SHALL be stall = out_valid AND NOT out_ready; in_ready SHALL equal NOT stall.
REQ-018 While stall=1, S1, S2, S3 and the accumulator SHALL hold all contents unchanged; c SHALL stay stable.
REQ-019 Bubbles (stage valid=0) SHALL advance with the pipeline and are not collapsed during stall.
REQ-020 Each product SHALL be truncated to the low WIDTH bits; the lane sum SHALL be computed modulo 2^WIDTH.
REQ-021 When a valid entry enters S3 with acc_mode=0: c = sum, accumulator = sum.
REQ-022 When a valid entry enters S3 with acc_mode=1: c = accumulator + sum (mod 2^WIDTH), accumulator = that value.
REQ-023 acc_mode SHALL travel with its operands through S1/S2; a change of the acc_mode input never affects entries already accepted.
REQ-024 Bubbles entering S3 SHALL leave accumulator unchanged; c SHALL retain its last value with out_valid=0.
REQ-025 Simultaneous output handshake and new input acceptance on the same edge SHALL both complete (full-rate streaming).

Reset
REQ-026 On a rising edge with reset=1: all stage valid bits=0, out_valid=0, c=0, accumulator=0, S1/S2 data=0.
REQ-027 During reset in_ready SHALL be 1 but inputs presented on the reset edge SHALL be discarded.
REQ-028 Reset mid-operation SHALL drop all in-flight entries; none SHALL appear on c after reset releases.
REQ-029 First accept SHALL be possible on the first edge after reset deasserts.

Verification
REQ-030 WIDTH=32, LANES=2, out_ready=1: accept A=(1,2),B=(3,4),acc_mode=0 at edge N, then A=(1,0),B=(1,0) at N+1 -> c=11 valid after N+2, c=1 valid after N+3, out_valid=0 after N+4.
REQ-031 Accumulate: (1,2)x(3,4) acc_mode=0, then (1,0)x(1,0) acc_mode=1, then (2,2)x(2,2) acc_mode=1 back-to-back -> c = 11, 12, 20 on consecutive cycles.
REQ-032 Backpressure: stream 4 inputs with sums 5,6,7,8, hold out_ready=0 for 3 cycles once c=5 is valid -> c=5 held stable, in_ready=0 for those cycles, then 5,6,7,8 each delivered exactly once in order.
REQ-033 Wrap: A=(0xFFFFFFFF,1),B=(2,1),acc_mode=0 -> c=0xFFFFFFFF; follow with A=(1,0),B=(1,0),acc_mode=1 -> c=0x00000000.
REQ-034 Reset mid-stream: accept 2 entries, assert reset for 1 edge one cycle later -> out_valid stays 0, c=0, next acc_mode=1 input (3)x(3) yields c=9.
REQ-035 Parameter sweep LANES=1,WIDTH=8: A=(16),B=(16) -> c=0x00; A=(15),B=(17) -> c=0xFF.
